// File: rtl/vga_frame_capture_pkg.sv
// Shared VGA timing constants, widths, state/payload types and helpers for the
// VGA frame-capture receiver.
package vga_frame_capture_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_BPORCH = 48;
  localparam int unsigned VGA_H_TOTAL  = 800;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_BPORCH = 33;
  localparam int unsigned VGA_V_TOTAL  = 525;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned LEN_W  = CNT_W + 1;
  localparam int unsigned RGB_W  = 3;
  localparam int unsigned CSUM_W = 16;

  typedef enum logic {
    ST_SEARCH  = 1'b0,
    ST_CAPTURE = 1'b1
  } cap_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic [RGB_W-1:0] rgb;
  } pixel_t;

  // Counters stick at all-ones so an overlong line/frame can never alias a valid length.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CSUM_W-1:0] csum_step(input logic [CSUM_W-1:0] acc,
                                                  input logic [RGB_W-1:0]  rgb);
    return {acc[CSUM_W-2:0], acc[CSUM_W-1]} ^ CSUM_W'(rgb);
  endfunction

endpackage

// File: rtl/vga_frame_capture_if.sv
// VGA scan-out bus as seen by the capture block: sync/RGB in, recovered pixel
// stream and frame status out.
interface vga_frame_capture_if;
  import vga_frame_capture_pkg::*;

  logic              iPixelEn;
  logic              iHsync;
  logic              iVsync;
  logic [RGB_W-1:0]  iRGB;
  logic              oPixelValid;
  logic [CNT_W-1:0]  oX;
  logic [CNT_W-1:0]  oY;
  logic [RGB_W-1:0]  oRGB;
  logic              oFrameDone;
  logic [CSUM_W-1:0] oFrameChecksum;
  logic              oLocked;
  logic              oSyncError;

  modport master (
    output iPixelEn, iHsync, iVsync, iRGB,
    input  oPixelValid, oX, oY, oRGB, oFrameDone, oFrameChecksum, oLocked, oSyncError
  );

  modport slave (
    input  iPixelEn, iHsync, iVsync, iRGB,
    output oPixelValid, oX, oY, oRGB, oFrameDone, oFrameChecksum, oLocked, oSyncError
  );
endinterface

// File: rtl/vga_frame_capture_sync_edge_detector.sv
// Samples a sync line on each enable and flags rise/fall between consecutive samples.
// The sample resets to the idle level so a quiet line produces no edge after reset.
module sync_edge_detector #(
  parameter logic IDLE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic rise_c,
  output logic fall_c
);

  logic sample_q, sample_d;

  always_comb begin
    sample_d = sample_q;
    if (en) sample_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sample_q <= IDLE;
    else     sample_q <= sample_d;
  end

  assign rise_c = en & d & ~sample_q;
  assign fall_c = en & ~d & sample_q;

endmodule

// File: rtl/vga_frame_capture.sv
// VGA receive-side monitor: recovers pixel coordinates from HSYNC/VSYNC, checks
// line/frame lengths and folds every visible pixel into a per-frame checksum.
module vga_frame_capture
  import vga_frame_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_BPORCH = VGA_H_BPORCH,
  parameter int unsigned H_TOTAL  = VGA_H_TOTAL,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_BPORCH = VGA_V_BPORCH,
  parameter int unsigned V_TOTAL  = VGA_V_TOTAL
) (
  input logic               clk,
  input logic               rst,
  vga_frame_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] H_FIRST = CNT_W'(H_BPORCH);
  localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_BPORCH + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_FIRST = CNT_W'(V_BPORCH);
  localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_BPORCH + V_ACTIVE);
  localparam logic [LEN_W-1:0] H_LEN   = LEN_W'(H_TOTAL);
  localparam logic [LEN_W-1:0] V_LEN   = LEN_W'(V_TOTAL);

  logic hs_rise_c, vs_rise_c, vs_fall_c, unused_hs_fall_c;

  sync_edge_detector #(.IDLE(1'b1)) u_hsync_edge (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.iPixelEn),
    .d      (bus.iHsync),
    .rise_c (hs_rise_c),
    .fall_c (unused_hs_fall_c)
  );

  sync_edge_detector #(.IDLE(1'b1)) u_vsync_edge (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.iPixelEn),
    .d      (bus.iVsync),
    .rise_c (vs_rise_c),
    .fall_c (vs_fall_c)
  );

  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  vcnt_q, vcnt_d;
  logic [CSUM_W-1:0] acc_q, acc_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  pixel_t            pix_q, pix_d;
  logic              pvalid_q, pvalid_d;
  logic              done_q, done_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic              h_err_c, v_err_c, visible_c;

  // Next-state, counters and checksum; everything advances only on a pixel enable.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    acc_d     = acc_q;
    csum_d    = csum_q;
    pix_d     = pix_q;
    locked_d  = locked_q;
    pvalid_d  = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    h_err_c   = 1'b0;
    v_err_c   = 1'b0;
    visible_c = 1'b0;

    if (bus.iPixelEn) begin
      hcnt_d = hs_rise_c ? '0 : sat_inc(hcnt_q);
      if (vs_rise_c)      vcnt_d = '0;
      else if (hs_rise_c) vcnt_d = sat_inc(vcnt_q);

      // Lengths are only trusted once capture started at a frame boundary.
      h_err_c = hs_rise_c && (state_q == ST_CAPTURE) && (({1'b0, hcnt_q} + LEN_W'(1)) != H_LEN);
      v_err_c = vs_rise_c && (state_q == ST_CAPTURE) && (({1'b0, vcnt_q} + LEN_W'(1)) != V_LEN);
      visible_c = (hcnt_d >= H_FIRST) && (hcnt_d < H_END) &&
                  (vcnt_d >= V_FIRST) && (vcnt_d < V_END);

      case (state_q)
        ST_SEARCH: begin
          acc_d = '0;
          if (vs_rise_c) state_d = ST_CAPTURE;
        end
        default: begin
          if (h_err_c || v_err_c) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            acc_d    = '0;
            state_d  = ST_SEARCH;
          end else begin
            if (vs_rise_c) locked_d = 1'b1;
            if (vs_fall_c) begin
              csum_d = acc_q;
              acc_d  = '0;
              done_d = 1'b1;
            end else if (visible_c) begin
              pvalid_d  = 1'b1;
              pix_d.x   = hcnt_d - H_FIRST;
              pix_d.y   = vcnt_d - V_FIRST;
              pix_d.rgb = bus.iRGB;
              acc_d     = csum_step(acc_q, bus.iRGB);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SEARCH;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      acc_q    <= '0;
      csum_q   <= '0;
      pix_q    <= '0;
      pvalid_q <= 1'b0;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      acc_q    <= acc_d;
      csum_q   <= csum_d;
      pix_q    <= pix_d;
      pvalid_q <= pvalid_d;
      done_q   <= done_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign bus.oPixelValid    = pvalid_q;
  assign bus.oX             = pix_q.x;
  assign bus.oY             = pix_q.y;
  assign bus.oRGB           = pix_q.rgb;
  assign bus.oFrameDone     = done_q;
  assign bus.oFrameChecksum = csum_q;
  assign bus.oLocked        = locked_q;
  assign bus.oSyncError     = err_q;

endmodule
